// File: rtl/maze_game_ctrl_if.sv
// Handshake bundle between the maze game controller and its keypad/display logic.
// The master drives the game inputs; the slave (the controller) drives state, page and countdown.
interface maze_game_ctrl_if;
    logic       tick;
    logic       start;
    logic       hit_wall;
    logic       at_exit;
    logic [1:0] state;
    logic       move_en;
    logic [1:0] page;
    logic [3:0] count1;
    logic [3:0] count0;
    logic       timer_run;

    modport master (
        output tick, start, hit_wall, at_exit,
        input  state, move_en, page, count1, count0, timer_run
    );

    modport slave (
        input  tick, start, hit_wall, at_exit,
        output state, move_en, page, count1, count0, timer_run
    );
endinterface

// File: rtl/maze_game_ctrl.sv
// Maze game controller: IDLE/PLAY/WIN/LOSE FSM with a BCD countdown and matrix page select.
// Optional feature macro MAZE_CTRL_AUTORESTART_EN: WIN/LOSE return to IDLE on the 3rd tick after entry.
module maze_game_ctrl #(
    parameter logic [3:0] LIMIT_TENS = 4'd2,
    parameter logic [3:0] LIMIT_ONES = 4'd0
) (
    input  logic              clk,
    input  logic              reset,
    maze_game_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_WIN  = 2'b10,
        ST_LOSE = 2'b11
    } state_t;

    state_t     state_r;
    state_t     state_next_s;
    logic [3:0] tens_r;
    logic [3:0] ones_r;
    logic [3:0] tens_next_s;
    logic [3:0] ones_next_s;
    logic       count_zero_s;

    function automatic logic [7:0] bcd_dec(input logic [3:0] tens, input logic [3:0] ones);
        if (ones == 4'd0) begin
            return {tens - 4'd1, 4'd9};
        end else begin
            return {tens, ones - 4'd1};
        end
    endfunction

    assign count_zero_s = (tens_r == 4'd0) && (ones_r == 4'd0);

`ifdef MAZE_CTRL_AUTORESTART_EN
    logic [1:0] ar_cnt_r;

    // Tick counter for the end-of-game screens; cleared whenever the screen is left
    always_ff @(posedge clk) begin
        if (!reset) begin
            ar_cnt_r <= 2'd0;
        end else if (((state_r == ST_WIN) || (state_r == ST_LOSE)) && (state_next_s != ST_IDLE)) begin
            if (bus.tick) begin
                ar_cnt_r <= ar_cnt_r + 2'd1;
            end else begin
                ar_cnt_r <= ar_cnt_r;
            end
        end else begin
            ar_cnt_r <= 2'd0;
        end
    end
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; a wall hit outranks timeout, which outranks reaching the exit
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_next_s = ST_PLAY;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_PLAY: begin
                if (bus.hit_wall) begin
                    state_next_s = ST_LOSE;
                end else if (count_zero_s) begin
                    state_next_s = ST_LOSE;
                end else if (bus.at_exit) begin
                    state_next_s = ST_WIN;
                end else begin
                    state_next_s = ST_PLAY;
                end
            end
            ST_WIN, ST_LOSE: begin
                if (bus.start) begin
                    state_next_s = ST_IDLE;
`ifdef MAZE_CTRL_AUTORESTART_EN
                end else if (bus.tick && (ar_cnt_r == 2'd2)) begin
                    state_next_s = ST_IDLE;
`endif
                end else begin
                    state_next_s = state_r;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Countdown next value; a tick on the exit edge still counts, after that the value is frozen
    always_comb begin
        tens_next_s = tens_r;
        ones_next_s = ones_r;
        if ((state_r == ST_IDLE) || (state_next_s == ST_IDLE)) begin
            tens_next_s = LIMIT_TENS;
            ones_next_s = LIMIT_ONES;
        end else if ((state_r == ST_PLAY) && bus.tick && !count_zero_s) begin
            {tens_next_s, ones_next_s} = bcd_dec(tens_r, ones_r);
        end else begin
            tens_next_s = tens_r;
            ones_next_s = ones_r;
        end
    end

    // Countdown register
    always_ff @(posedge clk) begin
        if (!reset) begin
            tens_r <= LIMIT_TENS;
            ones_r <= LIMIT_ONES;
        end else begin
            tens_r <= tens_next_s;
            ones_r <= ones_next_s;
        end
    end

    // Output decode from registered state only
    always_comb begin
        bus.state     = state_r;
        bus.count1    = tens_r;
        bus.count0    = ones_r;
        bus.move_en   = 1'b0;
        bus.timer_run = 1'b0;
        bus.page      = 2'b00;
        case (state_r)
            ST_PLAY: begin
                bus.move_en   = 1'b1;
                bus.timer_run = 1'b1;
                bus.page      = 2'b00;
            end
            ST_WIN: begin
                bus.page = 2'b10;
            end
            ST_LOSE: begin
                bus.page = 2'b11;
            end
            default: begin
                bus.page = 2'b00;
            end
        endcase
    end
endmodule

// File: doc/maze_game_ctrl.md
MAZE_GAME_CTRL -- requirements
Module: maze_game_ctrl

Interface
REQ-001 Parameter LIMIT_TENS, default 4'd2: BCD tens digit of the countdown start value.
REQ-002 Parameter LIMIT_ONES, default 4'd0: BCD ones digit of the countdown start value.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; sampled on rising clk edge.
REQ-005 tick  input  1  one-cycle-wide 1 s enable pulse.
REQ-006 start  input  1  one-cycle start/restart request from the keypad.
REQ-007 hit_wall  input  1  cursor overlaps a wall pixel (level).
REQ-008 at_exit  input  1  cursor sits on the exit cell (level).
REQ-009 state  output  2  game state: 00 IDLE, 01 PLAY, 10 WIN, 11 LOSE.
REQ-010 move_en  output  1  cursor movement permitted.
REQ-011 page  output  2  matrix page select: 00 maze, 10 smiley, 11 full green.
REQ-012 count1, count0  output  4 each  BCD tens/ones of remaining seconds.
REQ-013 timer_run  output  1  countdown active.

Function
REQ-014 All outputs shall be registered or decoded from registered state only; no input-to-output combinational path.
REQ-015 IDLE: count1/count0 shall hold LIMIT_TENS/LIMIT_ONES; page=00; move_en=0; timer_run=0.
REQ-016 IDLE with start=1 shall enter PLAY on the next edge; count is not decremented that cycle.
REQ-017 PLAY: move_en=1, timer_run=1, page=00.
REQ-018 PLAY with tick=1 and count nonzero shall decrement BCD: ones 0 -> 9 with tens-1, else ones-1; one step per tick.
REQ-019 Count shall never wrap below 00; tick at 00 shall leave 00.
REQ-020 PLAY exit priority, evaluated each cycle: hit_wall -> LOSE; else count==00 -> LOSE; else at_exit -> WIN; transition takes one clock.
REQ-021 Simultaneous tick and hit_wall/at_exit in PLAY: state transition taken, count still decremented that same edge, then frozen.
REQ-022 WIN: page=10, move_en=0, timer_run=0, count frozen at value present on entry.
REQ-023 LOSE: page=11, move_en=0, timer_run=0, count frozen.
REQ-024 start in PLAY shall be ignored; start in WIN or LOSE shall go to IDLE and reload the limit on the next edge.
REQ-025 hit_wall/at_exit outside PLAY shall be ignored.
REQ-026 Illegal BCD from parameters is not supported; LIMIT shall be nonzero.

Reset
REQ-027 reset=0 at a rising edge shall force state=IDLE, count=LIMIT, page=00, move_en=0, timer_run=0, overriding all other inputs, including mid-PLAY.
REQ-028 Auto-restart counter (if compiled in) shall clear to 0 on reset.

Configuration
REQ-029 Macro MAZE_CTRL_AUTORESTART_EN: when defined, WIN/LOSE shall count tick pulses and return to IDLE (limit reloaded) on the edge of the 3rd tick after entry; start still returns immediately.
REQ-030 Without MAZE_CTRL_AUTORESTART_EN, WIN/LOSE shall persist until start or reset; no extra counter logic exists.

Verification
REQ-031 Reset, start, 20 ticks, no hit -> count 19..00, LOSE one clock after 00, page=11, count stays 00 under further ticks.
REQ-032 Start, 5 ticks, hit_wall=1 -> LOSE, count frozen at 15, move_en=0.
REQ-033 Start, 3 ticks, at_exit=1 -> WIN, page=10, count 17; start pulse -> IDLE, count 20.
REQ-034 PLAY, hit_wall and at_exit asserted same cycle -> LOSE (priority); tick same edge -> count decremented once.
REQ-035 PLAY at count 12, reset=0 one edge -> IDLE, count 20, all outputs at reset values; start ignored during reset low.
REQ-036 With MAZE_CTRL_AUTORESTART_EN, WIN then 3 ticks -> IDLE on 3rd tick edge; without macro -> remains WIN after 10 ticks.
